// File: rtl/hsid_mse_ctrl_if.sv
// ---------------------------------------------------------------------------
// hsid_mse_ctrl_if
// Upstream band-word stream into the HSID MSE sequencing controller.
//   band_data_in_valid : source has a word pair this cycle
//   band_data_in_a     : packed pixel word (two bands)
//   band_data_in_b     : packed library word (two bands)
//   ready              : controller accepts; a beat transfers on valid && ready
// master = upstream source, slave = controller.
// ---------------------------------------------------------------------------
interface hsid_mse_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  band_data_in_valid;
  logic [WORD_WIDTH-1:0] band_data_in_a;
  logic [WORD_WIDTH-1:0] band_data_in_b;
  logic                  ready;

  modport master (
    output band_data_in_valid,
    output band_data_in_a,
    output band_data_in_b,
    input  ready
  );

  modport slave (
    input  band_data_in_valid,
    input  band_data_in_a,
    input  band_data_in_b,
    output ready
  );
endinterface

// File: rtl/hsid_mse_ctrl.sv
// ---------------------------------------------------------------------------
// hsid_mse_ctrl
// Sequencing controller for the two-channel MSE datapath. After start it
// frames the incoming word-pair stream per library entry, collects one MSE
// result per entry, tracks min/max MSE with their references, and pulses
// done once every result has arrived.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, cancel               run command / abort
//   hsp_library_size_in         library entries S (sampled on accepted start)
//   hsp_bands_in                bands per pixel B (sampled on accepted start)
//   up (slave)                  upstream valid / word a / word b / ready
//   dp_clear                    datapath clear strobe
//   dp_band_pack_*              beat framing and masked word pair
//   dp_hsp_ref, dp_hsp_bands    current library index, latched band count
//   dp_mse_valid/value/ref      datapath result strobe, value, reference
//   dp_acc_of                   datapath accumulator overflow
//   mse_min_*, mse_max_*        running min / max MSE and references
//   acc_of_flag                 sticky overflow over accepted results
//   done, idle                  completion pulse, idle status
// ---------------------------------------------------------------------------
module hsid_mse_ctrl #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cancel,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size_in,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands_in,
  hsid_mse_ctrl_if.slave               up,
  output logic                         dp_clear,
  output logic                         dp_band_pack_valid,
  output logic                         dp_band_pack_start,
  output logic                         dp_band_pack_last,
  output logic [WORD_WIDTH-1:0]        dp_band_pack_a,
  output logic [WORD_WIDTH-1:0]        dp_band_pack_b,
  output logic [HSP_LIBRARY_WIDTH-1:0] dp_hsp_ref,
  output logic [HSP_BANDS_WIDTH-1:0]   dp_hsp_bands,
  input  logic                         dp_mse_valid,
  input  logic                         dp_acc_of,
  input  logic [WORD_WIDTH-1:0]        dp_mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0] dp_mse_ref,
  output logic [WORD_WIDTH-1:0]        mse_min_value,
  output logic [WORD_WIDTH-1:0]        mse_max_value,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
  output logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
  output logic                         acc_of_flag,
  output logic                         done,
  output logic                         idle
);

  localparam int HALF = WORD_WIDTH / 2;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  // Zero the upper band of a word when the pixel has an odd band count and
  // this is the final word of the entry (only the lower band is real).
  function automatic logic [WORD_WIDTH-1:0] mask_upper(
    input logic [WORD_WIDTH-1:0] word,
    input logic                  en
  );
    return en ? {{HALF{1'b0}}, word[HALF-1:0]} : word;
  endfunction

  state_t                       state_q, state_d;
  logic [HSP_LIBRARY_WIDTH-1:0] size_q;
  logic [HSP_BANDS_WIDTH-1:0]   bands_q;
  logic [HSP_BANDS_WIDTH-1:0]   w_q;
  logic [HSP_LIBRARY_WIDTH-1:0] p_q;
  logic [HSP_LIBRARY_WIDTH:0]   r_q;
  logic [HSP_LIBRARY_WIDTH:0]   r_next;
  logic [HSP_BANDS_WIDTH-1:0]   words;
  logic                         beat, last_word, accept_start, abort, collect;
  logic [WORD_WIDTH-1:0]        min_q, max_q;
  logic [HSP_LIBRARY_WIDTH-1:0] min_ref_q, max_ref_q;
  logic                         acc_of_q;

  // ceil(B/2) words per entry, computed without a carry bit
  assign words     = (bands_q >> 1) + {{(HSP_BANDS_WIDTH-1){1'b0}}, bands_q[0]};
  assign last_word = (w_q == words - 1'b1);
  assign beat      = up.band_data_in_valid && (state_q == S_STREAM);
  assign collect   = dp_mse_valid && (state_q != S_IDLE) && !cancel;
  assign r_next    = r_q + {{HSP_LIBRARY_WIDTH{1'b0}}, dp_mse_valid};

  always_comb begin
    state_d      = state_q;
    accept_start = (state_q == S_IDLE) && start && !cancel;
    abort        = (state_q != S_IDLE) && cancel;
    dp_clear     = !rst && (accept_start || abort);
    up.ready     = (state_q == S_STREAM);
    idle         = (state_q == S_IDLE);
    done         = (state_q == S_DONE) && !cancel;
    unique case (state_q)
      S_IDLE: begin
        if (accept_start) begin
          if ((hsp_library_size_in == '0) || (hsp_bands_in == '0)) state_d = S_DONE;
          else                                                    state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (abort)                                               state_d = S_IDLE;
        else if (beat && last_word && (p_q == size_q - 1'b1))    state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                                               state_d = S_IDLE;
        else if (r_next == {1'b0, size_q})                       state_d = S_DONE;
      end
      S_DONE:                                                    state_d = S_IDLE;
      default:                                                   state_d = S_IDLE;
    endcase
  end

  // Beat framing is combinational: the datapath sees the word in the same
  // cycle it transfers.
  assign dp_band_pack_valid = beat;
  assign dp_band_pack_start = (w_q == '0);
  assign dp_band_pack_last  = last_word;
  assign dp_band_pack_a     = mask_upper(up.band_data_in_a, bands_q[0] && last_word);
  assign dp_band_pack_b     = mask_upper(up.band_data_in_b, bands_q[0] && last_word);
  assign dp_hsp_ref         = p_q;
  assign dp_hsp_bands       = bands_q;
  assign mse_min_value      = min_q;
  assign mse_max_value      = max_q;
  assign mse_min_ref        = min_ref_q;
  assign mse_max_ref        = max_ref_q;
  assign acc_of_flag        = acc_of_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= '0;
      bands_q   <= '0;
      w_q       <= '0;
      p_q       <= '0;
      r_q       <= '0;
      min_q     <= '0;
      max_q     <= '0;
      min_ref_q <= '0;
      max_ref_q <= '0;
      acc_of_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        size_q    <= hsp_library_size_in;
        bands_q   <= hsp_bands_in;
        w_q       <= '0;
        p_q       <= '0;
        r_q       <= '0;
        min_q     <= '1;
        max_q     <= '0;
        min_ref_q <= '0;
        max_ref_q <= '0;
        acc_of_q  <= 1'b0;
      end else begin
        if (beat) begin
          if (last_word) begin
            w_q <= '0;
            p_q <= p_q + 1'b1;
          end else begin
            w_q <= w_q + 1'b1;
          end
        end
        // Strict compares: on a tie the earlier reference is kept.
        if (collect) begin
          r_q <= r_next;
          if (dp_mse_value < min_q) begin
            min_q     <= dp_mse_value;
            min_ref_q <= dp_mse_ref;
          end
          if (dp_mse_value > max_q) begin
            max_q     <= dp_mse_value;
            max_ref_q <= dp_mse_ref;
          end
          acc_of_q <= acc_of_q | dp_acc_of;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsid_mse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hsid_mse_ctrl
// Directed bench for hsid_mse_ctrl. The MSE datapath is replaced by result
// strobes driven from the bench with hand-computed values.
// ---------------------------------------------------------------------------
module tb_hsid_mse_ctrl;

  localparam int WW = 32;
  localparam int BW = 9;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, start, cancel;
  logic [LW-1:0] lib_size;
  logic [BW-1:0] bands;
  logic          dp_clear, pk_valid, pk_start, pk_last;
  logic [WW-1:0] pk_a, pk_b;
  logic [LW-1:0] hsp_ref;
  logic [BW-1:0] hsp_bands;
  logic          mse_valid, acc_of;
  logic [WW-1:0] mse_value;
  logic [LW-1:0] mse_ref;
  logic [WW-1:0] min_v, max_v;
  logic [LW-1:0] min_r, max_r;
  logic          of_flag, done, idle;

  int n_checks = 0;
  int n_fail   = 0;

  hsid_mse_ctrl_if #(.WORD_WIDTH(WW)) up ();

  hsid_mse_ctrl #(
    .WORD_WIDTH(WW), .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel),
    .hsp_library_size_in(lib_size), .hsp_bands_in(bands),
    .up(up.slave),
    .dp_clear(dp_clear), .dp_band_pack_valid(pk_valid),
    .dp_band_pack_start(pk_start), .dp_band_pack_last(pk_last),
    .dp_band_pack_a(pk_a), .dp_band_pack_b(pk_b),
    .dp_hsp_ref(hsp_ref), .dp_hsp_bands(hsp_bands),
    .dp_mse_valid(mse_valid), .dp_acc_of(acc_of),
    .dp_mse_value(mse_value), .dp_mse_ref(mse_ref),
    .mse_min_value(min_v), .mse_max_value(max_v),
    .mse_min_ref(min_r), .mse_max_ref(max_r),
    .acc_of_flag(of_flag), .done(done), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Move to the drive point of the next cycle, well after the rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [LW-1:0] s, input logic [BW-1:0] b);
    nxt();
    start = 1'b1; lib_size = s; bands = b;
    #1;
    n_checks++;
    if (dp_clear !== 1'b1) begin n_fail++; $display("FAIL start_clear: got %b want 1", dp_clear); end
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL start_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_checks++;
    if ({up.ready, done, dp_clear, pk_valid, of_flag} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {up.ready, done, dp_clear, pk_valid, of_flag});
    end
    n_checks++;
    if ({min_v, max_v, min_r, max_r} !== '0) begin
      n_fail++; $display("FAIL reset_minmax: got %h %h %h %h want 0", min_v, max_v, min_r, max_r);
    end
    n_checks++;
    if (hsp_bands !== 9'd0) begin n_fail++; $display("FAIL reset_bands: got %0d want 0", hsp_bands); end
  endtask

  task automatic test_basic();
    issue_start(8'd2, 9'd2);
    nxt();
    start = 1'b0;
    up.band_data_in_valid = 1'b1; up.band_data_in_a = 32'h00030001; up.band_data_in_b = 32'h00010002;
    #1;
    n_checks++;
    if ({up.ready, pk_valid, pk_start, pk_last} !== 4'b1111) begin
      n_fail++; $display("FAIL basic_frame0: got %b want 1111", {up.ready, pk_valid, pk_start, pk_last});
    end
    n_checks++;
    if (pk_a !== 32'h00030001 || pk_b !== 32'h00010002) begin
      n_fail++; $display("FAIL basic_words0: got %h %h want 00030001 00010002", pk_a, pk_b);
    end
    n_checks++;
    if (hsp_ref !== 8'd0 || hsp_bands !== 9'd2) begin
      n_fail++; $display("FAIL basic_ref0: got %0d %0d want 0 2", hsp_ref, hsp_bands);
    end
    n_checks++;
    if (min_v !== 32'hFFFFFFFF || max_v !== 32'h0) begin
      n_fail++; $display("FAIL basic_init_minmax: got %h %h want ffffffff 0", min_v, max_v);
    end
    nxt();
    up.band_data_in_a = 32'h00040004; up.band_data_in_b = 32'h0;
    #1;
    n_checks++;
    if (hsp_ref !== 8'd1 || pk_last !== 1'b1 || pk_start !== 1'b1) begin
      n_fail++; $display("FAIL basic_frame1: got ref %0d last %b start %b want 1 1 1", hsp_ref, pk_last, pk_start);
    end
    nxt();
    up.band_data_in_valid = 1'b0;
    mse_valid = 1'b1; mse_value = 32'd2; mse_ref = 8'd0;
    #1;
    n_checks++;
    if (up.ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b want 0", up.ready); end
    nxt();
    mse_value = 32'd16; mse_ref = 8'd1;
    #1;
    n_checks++;
    if (done !== 1'b0 || min_v !== 32'd2) begin
      n_fail++; $display("FAIL basic_partial: got done %b min %0d want 0 2", done, min_v);
    end
    nxt();
    mse_valid = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
    n_checks++;
    if (min_v !== 32'd2 || min_r !== 8'd0 || max_v !== 32'd16 || max_r !== 8'd1 || of_flag !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: got min %0d/%0d max %0d/%0d of %b want 2/0 16/1 0",
                         min_v, min_r, max_v, max_r, of_flag);
    end
    nxt();
    #1;
    n_checks++;
    if (done !== 1'b0 || idle !== 1'b1 || min_v !== 32'd2) begin
      n_fail++; $display("FAIL basic_after: got done %b idle %b min %0d want 0 1 2", done, idle, min_v);
    end
  endtask

  task automatic test_odd_bands();
    issue_start(8'd1, 9'd3);
    nxt();
    start = 1'b0;
    up.band_data_in_valid = 1'b1; up.band_data_in_a = 32'h00020001; up.band_data_in_b = 32'h0;
    #1;
    n_checks++;
    if (pk_start !== 1'b1 || pk_last !== 1'b0 || pk_a !== 32'h00020001) begin
      n_fail++; $display("FAIL odd_w0: got start %b last %b a %h want 1 0 00020001", pk_start, pk_last, pk_a);
    end
    nxt();
    up.band_data_in_a = 32'hFFFF0003; up.band_data_in_b = 32'h12340000;
    #1;
    n_checks++;
    if (pk_a !== 32'h00000003 || pk_b !== 32'h0) begin
      n_fail++; $display("FAIL odd_mask: got %h %h want 00000003 00000000", pk_a, pk_b);
    end
    n_checks++;
    if (pk_start !== 1'b0 || pk_last !== 1'b1) begin
      n_fail++; $display("FAIL odd_w1_frame: got start %b last %b want 0 1", pk_start, pk_last);
    end
    nxt();
    up.band_data_in_valid = 1'b0;
    mse_valid = 1'b1; mse_value = 32'd4; mse_ref = 8'd0;
    #1;
    nxt();
    mse_valid = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1 || min_v !== 32'd4 || max_v !== 32'd4 || min_r !== 8'd0 || max_r !== 8'd0) begin
      n_fail++; $display("FAIL odd_result: got done %b min %0d/%0d max %0d/%0d want 1 4/0 4/0",
                         done, min_v, min_r, max_v, max_r);
    end
    nxt();
  endtask

  task automatic test_back_pressure();
    issue_start(8'd2, 9'd10);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        for (int g = 0; g < 3; g++) begin
          nxt();
          start = 1'b0;
          up.band_data_in_valid = 1'b0;
          #1;
          n_checks++;
          if (pk_valid !== 1'b0 || up.ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_gap%0d: got valid %b ready %b want 0 1", g, pk_valid, up.ready);
          end
        end
      end
      nxt();
      start = 1'b0;
      up.band_data_in_valid = 1'b1; up.band_data_in_a = k; up.band_data_in_b = k;
      #1;
      n_checks++;
      if (pk_valid !== 1'b1 || pk_start !== (k % 5 == 0) || pk_last !== (k % 5 == 4)
          || hsp_ref !== LW'(k / 5)) begin
        n_fail++; $display("FAIL bp_word%0d: got v %b s %b l %b ref %0d want 1 %b %b %0d",
                           k, pk_valid, pk_start, pk_last, hsp_ref, (k % 5 == 0), (k % 5 == 4), k / 5);
      end
    end
    nxt();
    up.band_data_in_valid = 1'b0;
    mse_valid = 1'b1; mse_value = 32'd10; mse_ref = 8'd0;
    #1;
    nxt();
    mse_value = 32'd20; mse_ref = 8'd1;
    #1;
    nxt();
    mse_valid = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1 || min_r !== 8'd0 || max_r !== 8'd1 || min_v !== 32'd10 || max_v !== 32'd20) begin
      n_fail++; $display("FAIL bp_result: got done %b min %0d/%0d max %0d/%0d want 1 10/0 20/1",
                         done, min_v, min_r, max_v, max_r);
    end
    nxt();
  endtask

  task automatic test_degenerate();
    logic [LW-1:0] sz [2];
    logic [BW-1:0] bd [2];
    sz[0] = 8'd0; bd[0] = 9'd5;
    sz[1] = 8'd3; bd[1] = 9'd0;
    for (int i = 0; i < 2; i++) begin
      issue_start(sz[i], bd[i]);
      nxt();
      start = 1'b0;
      #1;
      n_checks++;
      if (up.ready !== 1'b0 || done !== 1'b1) begin
        n_fail++; $display("FAIL degen%0d_done: got ready %b done %b want 0 1", i, up.ready, done);
      end
      nxt();
      #1;
      n_checks++;
      if (idle !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL degen%0d_idle: got idle %b done %b want 1 0", i, idle, done);
      end
    end
  endtask

  task automatic test_tie_overflow();
    logic [WW-1:0] vals [3];
    logic          ofs  [3];
    vals[0] = 32'd7; vals[1] = 32'd9; vals[2] = 32'd7;
    ofs[0]  = 1'b0;  ofs[1]  = 1'b1;  ofs[2]  = 1'b0;
    issue_start(8'd3, 9'd1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      start = 1'b0;
      up.band_data_in_valid = 1'b1;
      up.band_data_in_a = {16'hABCD, 16'(k + 5)};
      up.band_data_in_b = {16'h1234, 16'(k)};
      #1;
      n_checks++;
      if (pk_a !== {16'h0, 16'(k + 5)} || pk_b !== {16'h0, 16'(k)} || pk_start !== 1'b1
          || pk_last !== 1'b1 || hsp_ref !== LW'(k)) begin
        n_fail++; $display("FAIL tie_beat%0d: got a %h b %h s %b l %b ref %0d want %h %h 1 1 %0d",
                           k, pk_a, pk_b, pk_start, pk_last, hsp_ref, k + 5, k, k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      nxt();
      up.band_data_in_valid = 1'b0;
      mse_valid = 1'b1; mse_value = vals[k]; mse_ref = LW'(k); acc_of = ofs[k];
      #1;
    end
    nxt();
    mse_valid = 1'b0; acc_of = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL tie_done: got %b want 1", done); end
    n_checks++;
    if (min_v !== 32'd7 || min_r !== 8'd0 || max_v !== 32'd9 || max_r !== 8'd1) begin
      n_fail++; $display("FAIL tie_minmax: got min %0d/%0d max %0d/%0d want 7/0 9/1", min_v, min_r, max_v, max_r);
    end
    n_checks++;
    if (of_flag !== 1'b1) begin n_fail++; $display("FAIL tie_overflow: got %b want 1", of_flag); end
    nxt();
  endtask

  task automatic test_cancel_reset();
    issue_start(8'd3, 9'd2);
    nxt();
    start = 1'b0;
    up.band_data_in_valid = 1'b1; up.band_data_in_a = 32'h1; up.band_data_in_b = 32'h2;
    #1;
    nxt();
    cancel = 1'b1;
    #1;
    n_checks++;
    if (dp_clear !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL cancel_clear: got clear %b done %b want 1 0", dp_clear, done);
    end
    nxt();
    cancel = 1'b0; up.band_data_in_valid = 1'b0;
    #1;
    n_checks++;
    if (idle !== 1'b1 || up.ready !== 1'b0 || done !== 1'b0 || dp_clear !== 1'b0) begin
      n_fail++; $display("FAIL cancel_idle: got idle %b ready %b done %b clear %b want 1 0 0 0",
                         idle, up.ready, done, dp_clear);
    end
    nxt();
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL cancel_nodone: got %b want 0", done); end

    issue_start(8'd2, 9'd4);
    nxt();
    start = 1'b0;
    up.band_data_in_valid = 1'b1; up.band_data_in_a = 32'h5; up.band_data_in_b = 32'h6;
    mse_valid = 1'b1; mse_value = 32'd3; mse_ref = 8'd1; acc_of = 1'b1;
    #1;
    nxt();
    mse_valid = 1'b0; acc_of = 1'b0;
    #1;
    n_checks++;
    if (min_v !== 32'd3 || of_flag !== 1'b1 || hsp_bands !== 9'd4 || up.ready !== 1'b1) begin
      n_fail++; $display("FAIL prereset_state: got min %0d of %b bands %0d ready %b want 3 1 4 1",
                         min_v, of_flag, hsp_bands, up.ready);
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0; up.band_data_in_valid = 1'b0;
    #1;
    n_checks++;
    if (idle !== 1'b1 || {up.ready, done, dp_clear, pk_valid, of_flag} !== 5'b0) begin
      n_fail++; $display("FAIL rst_ctrl: got idle %b ctrl %b want 1 00000", idle,
                         {up.ready, done, dp_clear, pk_valid, of_flag});
    end
    n_checks++;
    if ({min_v, max_v, min_r, max_r} !== '0 || hsp_bands !== 9'd0 || hsp_ref !== 8'd0) begin
      n_fail++; $display("FAIL rst_data: got %h %h %h %h bands %0d ref %0d want all 0",
                         min_v, max_v, min_r, max_r, hsp_bands, hsp_ref);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; lib_size = '0; bands = '0;
    up.band_data_in_valid = 1'b0; up.band_data_in_a = '0; up.band_data_in_b = '0;
    mse_valid = 1'b0; acc_of = 1'b0; mse_value = '0; mse_ref = '0;
    test_reset();
    test_basic();
    test_odd_bands();
    test_back_pressure();
    test_degenerate();
    test_tie_overflow();
    test_cancel_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hsid_mse_ctrl.md
# hsid_mse_ctrl

Sequencing controller for the two-channel MSE datapath (`hsid_mse`) in the HSID accelerator. After a `start` command it:
- accepts a stream of packed band-word pairs (pixel word, library word) from upstream, and frames them per library entry (`band_pack_start`/`band_pack_last`/`hsp_ref`);
- collects one MSE result per library entry and tracks the minimum and maximum MSE and their library references;
- pulses `done` when all results are in.

## Interface
- WORD_WIDTH, 32, packed word width; two bands of WORD_WIDTH/2 bits per word
- HSP_BANDS_WIDTH, 9, width of band-count configuration
- HSP_LIBRARY_WIDTH, 8, width of library-size configuration and references

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  command; accepted only in IDLE
- cancel  in  1  abort current run
- hsp_library_size_in  in  HSP_LIBRARY_WIDTH  number of library entries; sampled on accepted start
- hsp_bands_in  in  HSP_BANDS_WIDTH  bands per pixel; sampled on accepted start
- band_data_in_valid  in  1  upstream word pair valid
- band_data_in_a, band_data_in_b  in  WORD_WIDTH each  pixel word / library word
- ready  out  1  upstream may transfer; a beat transfers on valid && ready
- dp_clear  out  1  clear to datapath
- dp_band_pack_valid, dp_band_pack_start, dp_band_pack_last  out  1 each  datapath framing
- dp_band_pack_a, dp_band_pack_b  out  WORD_WIDTH each  masked word pair
- dp_hsp_ref  out  HSP_LIBRARY_WIDTH  current library index
- dp_hsp_bands  out  HSP_BANDS_WIDTH  latched band count
- dp_mse_valid, dp_acc_of  in  1 each  datapath result strobe / overflow
- dp_mse_value  in  WORD_WIDTH  datapath result
- dp_mse_ref  in  HSP_LIBRARY_WIDTH  datapath result reference
- mse_min_value, mse_max_value  out  WORD_WIDTH each  running min / max MSE
- mse_min_ref, mse_max_ref  out  HSP_LIBRARY_WIDTH each  refs of min / max
- acc_of_flag  out  1  sticky OR of dp_acc_of over accepted results
- done  out  1  one-cycle completion pulse
- idle  out  1  high in IDLE

## Operation
- **States:** IDLE, STREAM, DRAIN, DONE.
- **IDLE:** `idle`=1.
  - `start`=1: latch size S and bands B; set `mse_min_value`=all-ones, `mse_max_value`=0, both refs=0, `acc_of_flag`=0; `dp_clear`=1 this cycle; clear counters.
  - S==0 or B==0: go to DONE. Otherwise go to STREAM.
- **STREAM:** `ready`=1.
  - Words per entry W=(B+1)>>1. Word counter w runs 0..W-1; entry counter p runs 0..S-1.
  - Datapath outputs are combinational from the beat: `dp_band_pack_valid`=valid&&ready, `dp_band_pack_start`=(w==0), `dp_band_pack_last`=(w==W-1), `dp_hsp_ref`=p.
  - When B is odd and w==W-1, the upper halves of a and b are forced to 0. Otherwise words pass unmodified.
  - On a beat with w==W-1: w←0 and p←p+1. If p==S-1, go to DRAIN (`ready`=0 from the next cycle).
- **Result collection (any non-IDLE state):** on each `dp_mse_valid`, increment result count r.
  - If `dp_mse_value` < min (strict): update min value and ref from `dp_mse_ref`.
  - If `dp_mse_value` > max (strict): update max value and ref. Ties keep the earlier ref.
  - OR `dp_acc_of` into `acc_of_flag`.
- **DRAIN:** go to DONE once r==S, including a result arriving on the same cycle.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. Results stay held until the next accepted start.
- **cancel** in STREAM/DRAIN/DONE: `dp_clear`=1 for one cycle, go to IDLE, no `done` pulse. Min/max are not reported as valid.
- `start` outside IDLE is ignored. If `start` and `cancel` are both high in IDLE, `start` is ignored.
- `dp_hsp_bands` = latched B.

## Timing
- **Reset values:** all outputs 0 (`mse_min_value`=0), except `idle`=1. State=IDLE.
- `rst` has priority over everything; reset mid-run behaves as cancel, with all outputs at reset values.
- start at cycle t → `ready`=1 at t+1 → first beat can transfer at t+1.
- The datapath beat appears on `dp_*` in the same cycle as the transfer (zero latency, no register).
- Last beat at cycle t → `ready`=0 at t+1.
- `done` occurs one cycle after the cycle in which r reaches S. `idle`=1 the cycle after `done`.
- S==0 or B==0: start at t → `done` at t+1 → `idle` at t+2.
- B==1: every beat is both start and last. Upper halves are masked.

## Test plan
- **Basic run (real hsid_mse attached):** B=2, S=2. Beat0 a=0x00030001 b=0x00010002 (MSE 5/2=2). Beat1 a=0x00040004 b=0 (MSE 32/2=16). Required: `mse_min_value`=2, ref 0; `mse_max_value`=16, ref 1; one `done` pulse; `acc_of_flag`=0.
- **Odd bands:** B=3, S=1. w0 a=0x00020001 b=0; w1 a=0xFFFF0003 b=0x12340000. Required: dp_a=0x00000003 and dp_b=0 on w1; MSE 14/3=4; min=max=4, ref 0.
- **Back-pressure gaps:** B=10, S=2 with valid deasserted for 3 cycles mid-entry. Required: framing unchanged (start on words 0 and 5, last on words 4 and 9); refs 0 then 1.
- **Degenerate configs:** S=0 and B=0. Required: no `ready`; `done` at t+1; `idle` at t+2.
- **Tie and overflow:** S=3 with equal MSE values on refs 0 and 2, and `dp_acc_of`=1 on ref 1. Required: min ref stays 0; `acc_of_flag`=1.
- **Cancel and reset:** assert `cancel` at the second beat, then assert `rst` mid-STREAM on a new run. Required: `dp_clear` pulse, no `done`, `idle`=1 next cycle; all outputs at reset values after `rst`.
